harmonic_scheduler: RTL and testbench
=====================================

Name: harmonic_scheduler

Overview:
- Standalone sequencer for the additive-synthesis datapath: sample-position lookup, per-parity scale multipliers, the even/odd accumulating adders and the DAC output stage.
- Each sample frame it walks harmonics 0..N-1 through a lookup → accumulate → rescale handshake chain, then latches totals, clears the adders and fires the DAC send on the sample-rate tick.
- Replaces the inline state machine in the top level and adds frame-overrun detection and a per-frame harmonic count.

Parameters:
NO_OF_HARMONICS, 50, harmonics processed per frame (indices 0..N-1); range 1..255
SAMPLE_INTERVAL, 1000, clocks per output sample (48 MHz / 48 kHz)
HARM_BITS, 8, width of the harmonic index and count
TIMER_BITS, 16, width of the sample timer

Ports:
i_Clock  in  1  main clock (48 MHz PLL output)
i_Reset  in  1  reset; synchronous, active-high
i_Sample_Ready  in  1  level; sample value valid for o_Harmonic
i_Freq_Too_High  in  1  level; current harmonic is above Nyquist
i_Adder_Done  in  2  one-cycle pulse per adder ([0] even, [1] odd); accumulate complete
i_Scaler_Ready  in  2  one-cycle pulse per scaler; new multiple valid
o_Harmonic  out  HARM_BITS  index of the harmonic being processed
o_Next_Sample  out  1  pulse; request lookup for o_Harmonic
o_Adder_Start  out  2  pulse; start adder [o_Harmonic[0]]
o_Scaler_Start  out  2  pulse; step scaler [o_Harmonic[0]]
o_Scaler_Restart  out  1  pulse; reload both scalers to their initial values
o_Adder_Clear  out  1  pulse; clear both accumulators
o_Latch_Totals  out  1  pulse; top level registers adder totals
o_DAC_Send  out  1  pulse; start DAC transfer
o_Harmonic_Count  out  HARM_BITS  harmonics accumulated in the last completed frame
o_Overrun  out  1  sticky; a frame missed its tick

Behaviour:
- Reset (sync, active-high; state, timer and pending flag all clear):
  - All outputs 0; state IDLE; timer 0.
  - Reset mid-operation discards the frame, with no partial pulses on the next cycle.
- Timer:
  - Free-running 0..SAMPLE_INTERVAL-1, wraps to 0, independent of the FSM.
  - tick = (timer == SAMPLE_INTERVAL-1).
  - tick sets `pending`. `pending` is cleared only in SEND; a tick in the same cycle as SEND re-sets it (set wins).
- All o_* strobes are exactly one cycle wide and registered.
- FSM:
  - IDLE: pulse o_Scaler_Restart and o_Next_Sample → ADD_START.
  - ADD_START:
    - i_Sample_Ready is ignored in the first cycle after entry (lookup blanking).
    - Thereafter, when i_Sample_Ready=1, pulse o_Adder_Start[o_Harmonic[0]] → ADD_WAIT.
  - ADD_WAIT: wait for i_Adder_Done[o_Harmonic[0]]. A pulse on the other bit is ignored. → NEXT.
  - NEXT:
    - o_Harmonic += 1 and pulse o_Next_Sample.
    - If (o_Harmonic == NO_OF_HARMONICS-1) or i_Freq_Too_High or pending: → LATCH.
    - Else → SCALE_START.
    - If the exit is caused by pending while the frame is incomplete and no stop condition applies, set o_Overrun.
  - SCALE_START: pulse o_Scaler_Start[o_Harmonic[0]] (the already-incremented index) → SCALE_WAIT.
  - SCALE_WAIT: wait for i_Scaler_Ready[o_Harmonic[0]] → ADD_START.
  - LATCH: pulse o_Latch_Totals; o_Harmonic_Count <= o_Harmonic → CLEAR.
  - CLEAR: pulse o_Adder_Clear → WAIT_TICK.
  - WAIT_TICK: when pending=1 (or tick this cycle) → SEND.
  - SEND:
    - Pulse o_DAC_Send, o_Scaler_Restart and o_Next_Sample; o_Harmonic <= 0; clear pending → ADD_START.
- Harmonic 0 uses the scaler initial value, so there is no scale step before it.
- Latency and rate:
  - In steady state, o_DAC_Send fires in the cycle after each tick, so the DAC period is exactly SAMPLE_INTERVAL.
  - Per harmonic with 1-cycle responders: ADD_START(2) + ADD_WAIT(1) + NEXT(1) + SCALE(2) = 6 clocks.
- o_Harmonic never exceeds NO_OF_HARMONICS.
- o_Overrun stays set until reset.
- After an overrun frame the next frame starts immediately, aligned to the following tick.

Test Plan:
1. NO_OF_HARMONICS=4, SAMPLE_INTERVAL=100, stub responders reply in 1 cycle, release reset → o_Adder_Start pulses [0],[1],[0],[1] with o_Harmonic 0,1,2,3; one o_Latch_Totals; o_Harmonic_Count=4; o_DAC_Send in the cycle after timer=99, then every 100 clocks; o_Overrun=0.
2. Same setup, assert i_Freq_Too_High during harmonic 1's ADD_WAIT → frame latches after 2 harmonics, o_Harmonic_Count=2, no o_Scaler_Start for harmonic 2, o_Overrun=0.
3. Adder responder delays done by 40 cycles, interval 100, N=4 → tick arrives mid-frame; frame ends at the next NEXT state; o_Overrun=1 and sticky; o_DAC_Send within 5 clocks of LATCH; o_Harmonic_Count<4.
4. Hold i_Sample_Ready=1 continuously → exactly one o_Adder_Start per harmonic, never in the first ADD_START cycle.
5. Assert i_Reset for 1 cycle during ADD_WAIT of harmonic 2 → next cycle all outputs 0 and timer 0; then IDLE restart pulses (o_Scaler_Restart, o_Next_Sample) and a clean frame from harmonic 0.
6. Pulse i_Adder_Done[1] while waiting on adder [0] → ignored; FSM advances only on the [0] pulse.

Source files
------------

// File: rtl/harmonic_scheduler.sv
// harmonic_scheduler
//   Frame sequencer for the additive-synthesis datapath. Once per sample frame it
//   walks harmonics 0..NO_OF_HARMONICS-1 through lookup -> accumulate -> rescale,
//   then latches the totals, clears the accumulators and fires the DAC send on
//   the sample-rate tick. A frame still running when the tick arrives is cut
//   short at its next harmonic boundary and flagged as an overrun.
//
// Ports
//   i_Clock, i_Reset        clock; synchronous active-high reset
//   i_Sample_Ready          level: lookup value valid for o_Harmonic
//   i_Freq_Too_High         level: current harmonic is above Nyquist
//   i_Adder_Done[1:0]       pulse per adder ([0] even, [1] odd): accumulate done
//   i_Scaler_Ready[1:0]     pulse per scaler: new multiple valid
//   o_Harmonic              index of the harmonic being processed
//   o_Next_Sample           pulse: request lookup for o_Harmonic
//   o_Adder_Start[1:0]      pulse: start adder selected by harmonic parity
//   o_Scaler_Start[1:0]     pulse: step scaler selected by harmonic parity
//   o_Scaler_Restart        pulse: reload both scalers to their initial values
//   o_Adder_Clear           pulse: clear both accumulators
//   o_Latch_Totals          pulse: top level registers the adder totals
//   o_DAC_Send              pulse: start DAC transfer
//   o_Harmonic_Count        harmonics accumulated in the last completed frame
//   o_Overrun               sticky: a frame missed its tick
//
// All strobes are registered and exactly one cycle wide. Each strobe is raised
// on the clock edge that performs the corresponding action, so it is visible in
// the cycle that follows; the DAC send is raised on entry to SEND so that it
// lands in the cycle right after the tick.

module harmonic_scheduler #(
    parameter int NO_OF_HARMONICS = 50,
    parameter int SAMPLE_INTERVAL = 1000,
    parameter int HARM_BITS       = 8,
    parameter int TIMER_BITS      = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Sample_Ready,
    input  logic                 i_Freq_Too_High,
    input  logic [1:0]           i_Adder_Done,
    input  logic [1:0]           i_Scaler_Ready,
    output logic [HARM_BITS-1:0] o_Harmonic,
    output logic                 o_Next_Sample,
    output logic [1:0]           o_Adder_Start,
    output logic [1:0]           o_Scaler_Start,
    output logic                 o_Scaler_Restart,
    output logic                 o_Adder_Clear,
    output logic                 o_Latch_Totals,
    output logic                 o_DAC_Send,
    output logic [HARM_BITS-1:0] o_Harmonic_Count,
    output logic                 o_Overrun
);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_ADD_START   = 4'd1;
    localparam logic [3:0] S_ADD_WAIT    = 4'd2;
    localparam logic [3:0] S_NEXT        = 4'd3;
    localparam logic [3:0] S_SCALE_START = 4'd4;
    localparam logic [3:0] S_SCALE_WAIT  = 4'd5;
    localparam logic [3:0] S_LATCH       = 4'd6;
    localparam logic [3:0] S_CLEAR       = 4'd7;
    localparam logic [3:0] S_WAIT_TICK   = 4'd8;
    localparam logic [3:0] S_SEND        = 4'd9;

    localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(SAMPLE_INTERVAL - 1);
    localparam logic [HARM_BITS-1:0]  HARM_LAST  = HARM_BITS'(NO_OF_HARMONICS - 1);

    logic [3:0]            state;
    logic [TIMER_BITS-1:0] timer;
    logic                  tick;
    logic                  pending;
    logic                  blank;        // first ADD_START cycle: lookup still settling
    logic [1:0]            parity_mask;  // one-hot adder/scaler select for o_Harmonic
    logic                  last_harm;
    logic                  frame_stop;

    assign tick        = (timer == TIMER_LAST);
    assign parity_mask = o_Harmonic[0] ? 2'b10 : 2'b01;
    assign last_harm   = (o_Harmonic == HARM_LAST);
    assign frame_stop  = last_harm | i_Freq_Too_High | pending;

    // Sample-rate timer, free-running and independent of the FSM.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // A tick in the same cycle as SEND wins, so no tick is ever lost.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            pending <= 1'b0;
        end else if (tick) begin
            pending <= 1'b1;
        end else if (state == S_SEND) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            // NOTE: every register here is control state, so all of it is
            // reset; a reset mid-frame must leave no stray strobe behind.
            state            <= S_IDLE;
            blank            <= 1'b0;
            o_Harmonic       <= '0;
            o_Next_Sample    <= 1'b0;
            o_Adder_Start    <= 2'b00;
            o_Scaler_Start   <= 2'b00;
            o_Scaler_Restart <= 1'b0;
            o_Adder_Clear    <= 1'b0;
            o_Latch_Totals   <= 1'b0;
            o_DAC_Send       <= 1'b0;
            o_Harmonic_Count <= '0;
            o_Overrun        <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; the strobe defaults below are
            // overridden by the case arms, last assignment wins.
            o_Next_Sample    <= 1'b0;
            o_Adder_Start    <= 2'b00;
            o_Scaler_Start   <= 2'b00;
            o_Scaler_Restart <= 1'b0;
            o_Adder_Clear    <= 1'b0;
            o_Latch_Totals   <= 1'b0;
            o_DAC_Send       <= 1'b0;

            case (state)
                S_IDLE: begin
                    o_Scaler_Restart <= 1'b1;
                    o_Next_Sample    <= 1'b1;
                    blank            <= 1'b1;
                    state            <= S_ADD_START;
                end
                S_ADD_START: begin
                    if (blank) begin
                        blank <= 1'b0;
                    end else if (i_Sample_Ready) begin
                        o_Adder_Start <= parity_mask;
                        state         <= S_ADD_WAIT;
                    end
                end
                S_ADD_WAIT: begin
                    // Only the adder for this harmonic's parity can complete it.
                    if ((i_Adder_Done & parity_mask) != 2'b00) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    o_Harmonic    <= o_Harmonic + 1'b1;
                    o_Next_Sample <= 1'b1;
                    if (frame_stop) begin
                        state <= S_LATCH;
                        // Cut short only by the tick: the frame ran out of time.
                        if (pending && !last_harm && !i_Freq_Too_High) begin
                            o_Overrun <= 1'b1;
                        end
                    end else begin
                        state <= S_SCALE_START;
                    end
                end
                S_SCALE_START: begin
                    // o_Harmonic already points at the next harmonic here.
                    o_Scaler_Start <= parity_mask;
                    state          <= S_SCALE_WAIT;
                end
                S_SCALE_WAIT: begin
                    if ((i_Scaler_Ready & parity_mask) != 2'b00) begin
                        blank <= 1'b1;
                        state <= S_ADD_START;
                    end
                end
                S_LATCH: begin
                    o_Latch_Totals   <= 1'b1;
                    o_Harmonic_Count <= o_Harmonic;
                    state            <= S_CLEAR;
                end
                S_CLEAR: begin
                    o_Adder_Clear <= 1'b1;
                    state         <= S_WAIT_TICK;
                end
                S_WAIT_TICK: begin
                    // Strobes raised here appear during SEND, one cycle after the tick.
                    if (pending || tick) begin
                        o_DAC_Send       <= 1'b1;
                        o_Scaler_Restart <= 1'b1;
                        o_Next_Sample    <= 1'b1;
                        o_Harmonic       <= '0;
                        state            <= S_SEND;
                    end
                end
                S_SEND: begin
                    blank <= 1'b1;
                    state <= S_ADD_START;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Directed bench for harmonic_scheduler with N=4 harmonics and a 100-clock
// sample interval. Responders live in the bench: the scaler answers in the
// same cycle its start strobe is seen, the adder after a configurable delay,
// and the lookup is always ready. Event times are logged in cycles relative
// to the first cycle after reset (R); expectations are hand-derived timelines.

module tb_harmonic_scheduler;

    localparam int N  = 4;
    localparam int SI = 100;

    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Sample_Ready = 1'b1;
    logic       i_Freq_Too_High = 1'b0;
    logic [1:0] i_Adder_Done = 2'b00;
    logic [1:0] i_Scaler_Ready = 2'b00;
    logic [7:0] o_Harmonic;
    logic       o_Next_Sample;
    logic [1:0] o_Adder_Start;
    logic [1:0] o_Scaler_Start;
    logic       o_Scaler_Restart;
    logic       o_Adder_Clear;
    logic       o_Latch_Totals;
    logic       o_DAC_Send;
    logic [7:0] o_Harmonic_Count;
    logic       o_Overrun;

    harmonic_scheduler #(
        .NO_OF_HARMONICS(N),
        .SAMPLE_INTERVAL(SI),
        .HARM_BITS(8),
        .TIMER_BITS(16)
    ) dut (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_Sample_Ready(i_Sample_Ready),
        .i_Freq_Too_High(i_Freq_Too_High),
        .i_Adder_Done(i_Adder_Done),
        .i_Scaler_Ready(i_Scaler_Ready),
        .o_Harmonic(o_Harmonic),
        .o_Next_Sample(o_Next_Sample),
        .o_Adder_Start(o_Adder_Start),
        .o_Scaler_Start(o_Scaler_Start),
        .o_Scaler_Restart(o_Scaler_Restart),
        .o_Adder_Clear(o_Adder_Clear),
        .o_Latch_Totals(o_Latch_Totals),
        .o_DAC_Send(o_DAC_Send),
        .o_Harmonic_Count(o_Harmonic_Count),
        .o_Overrun(o_Overrun)
    );

    always #5 i_Clock = ~i_Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle counter; read on the falling edge.
    int   cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge i_Clock) begin
        cyc      <= cyc + 1;
        rst_seen <= i_Reset;
    end

    // Responder configuration, written only by the stimulus block.
    int adder_delay  = 0;
    bit inject_wrong = 1'b0;
    bit ftz_mode     = 1'b0;

    int acd [2];
    int wcd = 0;

    always @(negedge i_Clock) begin
        logic [1:0] ad;
        ad = 2'b00;
        if (rst_seen) begin
            acd[0] = 0;
            acd[1] = 0;
            wcd = 0;
            i_Freq_Too_High = 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (acd[b] > 0) begin
                    acd[b]--;
                    if (acd[b] == 0) ad[b] = 1'b1;
                end
                if (o_Adder_Start[b]) begin
                    if (adder_delay == 0) ad[b] = 1'b1;
                    else acd[b] = adder_delay;
                end
            end
            if (wcd > 0) begin
                wcd--;
                if (wcd == 0) ad[1] = 1'b1;
            end
            if (inject_wrong && o_Adder_Start[0]) wcd = 2;
            if (ftz_mode && o_Adder_Start[1] && o_Harmonic == 8'd1) i_Freq_Too_High = 1'b1;
            if (o_Latch_Totals || !ftz_mode) i_Freq_Too_High = 1'b0;
        end
        i_Adder_Done   = ad;
        i_Scaler_Ready = o_Scaler_Start;
    end

    // Event log (absolute cycle stamps) and protocol invariants.
    int as_t[$], as_b[$], as_h[$], ss_t[$], lt_t[$], dac_t[$], rs_t[$];
    int viol = 0;
    logic [8:0] prev_strobes = '0;

    always @(negedge i_Clock) begin
        logic [8:0] strobes;
        strobes = {o_Next_Sample, o_Adder_Start, o_Scaler_Start, o_Scaler_Restart,
                   o_Adder_Clear, o_Latch_Totals, o_DAC_Send};
        if (o_Adder_Start != 2'b00) begin
            as_t.push_back(cyc);
            as_b.push_back(int'(o_Adder_Start));
            as_h.push_back(int'(o_Harmonic));
        end
        if (o_Scaler_Start != 2'b00) ss_t.push_back(cyc);
        if (o_Latch_Totals)          lt_t.push_back(cyc);
        if (o_DAC_Send)              dac_t.push_back(cyc);
        if (o_Scaler_Restart)        rs_t.push_back(cyc);
        if (o_Harmonic > 8'(N))      viol++;
        if ((strobes & prev_strobes) != '0) viol++;
        prev_strobes = strobes;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int idx);
        if (idx >= 0 && idx < q.size()) return q[idx];
        return -1;
    endfunction

    function automatic int count_before(input int q[$], input int base, input int lim);
        int n = 0;
        for (int i = base; i < q.size(); i++) if (q[i] < lim) n++;
        return n;
    endfunction

    int r, b_as, b_ss, b_lt, b_dac, b_rs;

    task automatic snap_bases();
        r     = cyc;
        b_as  = as_t.size();
        b_ss  = ss_t.size();
        b_lt  = lt_t.size();
        b_dac = dac_t.size();
        b_rs  = rs_t.size();
    endtask

    task automatic do_reset();
        @(negedge i_Clock);
        i_Reset = 1'b1;
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b0;
        snap_bases();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge i_Clock);
    endtask

    logic [25:0] all_outs;
    bit found;

    initial begin
        // ---- Test 1: nominal frame, reset state, DAC cadence ----
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;
        snap_bases();
        all_outs = {o_Harmonic, o_Next_Sample, o_Adder_Start, o_Scaler_Start, o_Scaler_Restart,
                    o_Adder_Clear, o_Latch_Totals, o_DAC_Send, o_Harmonic_Count, o_Overrun};
        check("t1_reset_outputs", all_outs, 26'd0);
        wait_cycles(205);
        for (int k = 0; k < N; k++) begin
            check($sformatf("t1_as_harm%0d", k), at(as_h, b_as + k), k);
            check($sformatf("t1_as_bit%0d", k), at(as_b, b_as + k), (k % 2) ? 2 : 1);
            check($sformatf("t1_as_time%0d", k), at(as_t, b_as + k) - r, 3 + 6 * k);
        end
        check("t1_as_count_frame", count_before(as_t, b_as, r + SI), N);
        check("t1_scaler_starts", count_before(ss_t, b_ss, r + SI), N - 1);
        check("t1_latch_count", count_before(lt_t, b_lt, r + SI), 1);
        check("t1_latch_time", at(lt_t, b_lt) - r, 24);
        check("t1_harm_count", o_Harmonic_Count, N);
        check("t1_dac_first", at(dac_t, b_dac) - r, SI);
        check("t1_dac_period", at(dac_t, b_dac + 1) - at(dac_t, b_dac), SI);
        check("t1_overrun", o_Overrun, 1'b0);
        // ---- Test 4: lookup blanking with i_Sample_Ready held high ----
        check("t4_blank_after_idle", at(as_t, b_as) - at(rs_t, b_rs), 2);
        check("t4_blank_after_send", at(as_t, b_as + N) - at(dac_t, b_dac), 3);

        // ---- Test 2: above-Nyquist stop after harmonic 1 ----
        ftz_mode = 1'b1;
        do_reset();
        wait_cycles(105);
        check("t2_harm_count", o_Harmonic_Count, 2);
        check("t2_latch_time", at(lt_t, b_lt) - r, 12);
        check("t2_scaler_starts", count_before(ss_t, b_ss, r + SI), 1);
        check("t2_adder_starts", count_before(as_t, b_as, r + SI), 2);
        check("t2_dac_first", at(dac_t, b_dac) - r, SI);
        check("t2_overrun", o_Overrun, 1'b0);
        ftz_mode = 1'b0;

        // ---- Test 3: slow adders, tick lands mid-frame ----
        adder_delay = 40;
        do_reset();
        wait_cycles(150);
        check("t3_overrun", o_Overrun, 1'b1);
        check("t3_harm_count", o_Harmonic_Count, 3);
        check("t3_latch_time", at(lt_t, b_lt) - r, 138);
        check("t3_dac_time", at(dac_t, b_dac) - r, 140);
        check("t3_dac_near_latch", (at(dac_t, b_dac) - at(lt_t, b_lt)) <= 5, 1);
        wait_cycles(100);
        check("t3_overrun_sticky", o_Overrun, 1'b1);

        // ---- Test 5: reset during ADD_WAIT of harmonic 2 ----
        adder_delay = 0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge i_Clock);
            if (o_Adder_Start[0] && o_Harmonic == 8'd2) found = 1'b1;
        end
        check("t5_reached_harm2", found, 1'b1);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        snap_bases();
        all_outs = {o_Harmonic, o_Next_Sample, o_Adder_Start, o_Scaler_Start, o_Scaler_Restart,
                    o_Adder_Clear, o_Latch_Totals, o_DAC_Send, o_Harmonic_Count, o_Overrun};
        check("t5_outputs_cleared", all_outs, 26'd0);
        wait_cycles(105);
        check("t5_restart_time", at(rs_t, b_rs) - r, 1);
        check("t5_first_harm", at(as_h, b_as), 0);
        check("t5_first_start", at(as_t, b_as) - r, 3);
        check("t5_timer_cleared", at(dac_t, b_dac) - r, SI);
        check("t5_harm_count", o_Harmonic_Count, N);

        // ---- Test 6: stray done on the wrong adder is ignored ----
        adder_delay  = 5;
        inject_wrong = 1'b1;
        do_reset();
        wait_cycles(60);
        check("t6_harm_gap", at(as_t, b_as + 1) - at(as_t, b_as), 11);
        check("t6_last_start", at(as_t, b_as + 3) - r, 36);
        check("t6_harm_count", o_Harmonic_Count, N);
        inject_wrong = 1'b0;

        check("invariants", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
